chip_cfg_writer: RTL and testbench
==================================

Name: chip_cfg_writer

Overview:
- Chip-side physical write engine for the sensor configuration path.
- Accepts single-bit row/column shift-register write requests and key-write requests from the configuration FSM.
- Produces the timed serial data, shift-clock and key-strobe pins to the sensor chip.
- Returns a one-cycle write-done pulse, which the configuration FSM consumes as its chip-write-ready input.

Parameters:
- CLK_DIV, 2, system-clock cycles per shift-clock phase (low phase and high phase each); legal range 1..255.
- KEY_PULSE, 4, system-clock cycles that o_chip_key is held high; legal range 1..255.
- NB_CNT, 8, width of the shifted-bit counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_row_reg_data  in  1  bit to shift into the row register.
- i_row_reg_write  in  1  row shift request (level, held until done).
- i_col_reg_data  in  1  bit to shift into the column register.
- i_col_reg_write  in  1  column shift request (level, held until done).
- i_key_wren  in  1  key-write request (level, held until done).
- i_cnt_clear  in  1  synchronous clear of both bit counters.
- o_write_ready  out  1  one-cycle done pulse.
- o_busy  out  1  high in every state except IDLE.
- o_chip_row_data  out  1  row serial data pin.
- o_chip_row_clk  out  1  row shift clock pin.
- o_chip_col_data  out  1  column serial data pin.
- o_chip_col_clk  out  1  column shift clock pin.
- o_chip_key  out  1  key latch strobe pin.
- o_row_count  out  NB_CNT  row bits shifted since the last clear.
- o_col_count  out  NB_CNT  column bits shifted since the last clear.

Behaviour:
- Reset: all outputs 0, state IDLE, both counters 0. Reset asserted mid-transaction aborts it immediately: pins go low and no done pulse is issued.
- States: IDLE, SETUP, HIGH, KEY, DONE.
- IDLE:
  - If any request is high, register req_row, req_col, req_key, row_data and col_data.
  - Next state is SETUP if req_row or req_col is set, else KEY.
  - No request: stay in IDLE.
- SETUP:
  - Data pins driven from the registered bits for every selected register; unselected data pins hold their previous value.
  - Shift clocks low; stay CLK_DIV cycles.
- HIGH:
  - o_chip_row_clk is high only if req_row; o_chip_col_clk is high only if req_col. Data pins stay stable.
  - Stay CLK_DIV cycles.
  - On exit, increment the selected counters. Counters wrap modulo 2^NB_CNT.
  - Next state is KEY if req_key, else DONE.
- KEY: o_chip_key high for KEY_PULSE cycles, then DONE.
- DONE: o_write_ready = 1 for exactly one cycle; requests are ignored in this cycle; next state is IDLE.
- Requesters must deassert or change requests on the edge that samples the done pulse. A request still high in IDLE starts a new transaction.
- Latency from the IDLE capture edge to o_write_ready high:
  - shift only: 2*CLK_DIV+1 cycles;
  - shift and key: 2*CLK_DIV+KEY_PULSE+1 cycles;
  - key only: KEY_PULSE+1 cycles.
- Simultaneous row and column requests form one transaction: both clocks toggle together and a single done pulse is issued.
- A key request together with a shift request: shift first, then key, then a single done pulse.
- Request inputs are sampled only in IDLE; changes during a transaction are ignored.
- i_cnt_clear has priority over a same-cycle increment.
- All chip pins are registered outputs (no combinational path from inputs to pins).

Test Plan:
- Reset with CLK_DIV=2. Row write with data=1 held in IDLE -> o_chip_row_data=1; row_clk low for 2 cycles, then high for 2 cycles; col_clk stays 0; o_write_ready pulses 5 cycles after capture; o_row_count=1.
- Row (data 0) and column (data 1) requested in the same cycle -> both clocks pulse together; one done pulse; o_row_count=1 and o_col_count=1.
- Key only with KEY_PULSE=4 -> o_chip_key high exactly 4 cycles; done pulse on the 5th cycle; shift clocks and counters unchanged.
- Column write and key together -> full column clock pulse, then 4-cycle key strobe, then one done pulse 9 cycles after capture.
- Requester holds the request through the done pulse and drops it the following cycle -> exactly one transaction. Holding it longer -> second transaction starts from IDLE.
- Assert rst while in HIGH -> all pins 0 immediately; no o_write_ready; counters 0. Then 256 row writes with NB_CNT=8 -> o_row_count wraps to 0. Asserting i_cnt_clear coincident with an increment -> count 0.

Source files
------------

// File: rtl/chip_cfg_writer.sv
// chip_cfg_writer
//   Chip-side physical write engine for the sensor configuration path.
//   It takes one row and/or column shift-register bit, and/or a key write,
//   from the configuration FSM. It drives the sensor's serial data pins,
//   shift-clock pins and key strobe pin with the required timing, and it
//   returns a single-cycle done pulse.
//
//   Handshake: i_row_reg_write, i_col_reg_write and i_key_wren are levels.
//   They are sampled only in IDLE. The requester holds them until it
//   samples o_write_ready high, and it drops or changes them on that same
//   edge. During the done cycle the engine ignores the requests. A request
//   that is still high in the following IDLE cycle starts a new transaction.
//
// Ports
//   clk, rst                            system clock, async active-high reset
//   i_row_reg_data / i_row_reg_write    row bit and row shift request
//   i_col_reg_data / i_col_reg_write    column bit and column shift request
//   i_key_wren                          key-write request
//   i_cnt_clear                         synchronous clear of both bit counters
//   o_write_ready                       one-cycle done pulse
//   o_busy                              high whenever the FSM is not in IDLE
//   o_chip_row_data / o_chip_row_clk    row serial data and shift clock pins
//   o_chip_col_data / o_chip_col_clk    column serial data and shift clock pins
//   o_chip_key                          key latch strobe pin
//   o_row_count / o_col_count           bits shifted since the last clear
module chip_cfg_writer #(
  parameter int CLK_DIV   = 2,
  parameter int KEY_PULSE = 4,
  parameter int NB_CNT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_row_reg_data,
  input  logic              i_row_reg_write,
  input  logic              i_col_reg_data,
  input  logic              i_col_reg_write,
  input  logic              i_key_wren,
  input  logic              i_cnt_clear,
  output logic              o_write_ready,
  output logic              o_busy,
  output logic              o_chip_row_data,
  output logic              o_chip_row_clk,
  output logic              o_chip_col_data,
  output logic              o_chip_col_clk,
  output logic              o_chip_key,
  output logic [NB_CNT-1:0] o_row_count,
  output logic [NB_CNT-1:0] o_col_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_KEY   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The dwell timer counts down to zero. It is loaded with length-1 on entry
  // to each timed state.
  localparam logic [7:0] SHIFT_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] KEY_LOAD   = 8'(KEY_PULSE - 1);

  state_t              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic                req_row_q, req_row_d;
  logic                req_col_q, req_col_d;
  logic                req_key_q, req_key_d;
  logic                row_data_q, row_data_d;
  logic                col_data_q, col_data_d;
  logic                row_clk_q, row_clk_d;
  logic                col_clk_q, col_clk_d;
  logic                key_q, key_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [NB_CNT-1:0]   row_cnt_q, row_cnt_d;
  logic [NB_CNT-1:0]   col_cnt_q, col_cnt_d;
  logic                inc_row, inc_col;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    req_row_d  = req_row_q;
    req_col_d  = req_col_q;
    req_key_d  = req_key_q;
    row_data_d = row_data_q;
    col_data_d = col_data_q;
    inc_row    = 1'b0;
    inc_col    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_row_reg_write || i_col_reg_write || i_key_wren) begin
          req_row_d = i_row_reg_write;
          req_col_d = i_col_reg_write;
          req_key_d = i_key_wren;
          // Data pins load as the FSM enters SETUP. Unselected pins keep
          // their old value.
          if (i_row_reg_write) row_data_d = i_row_reg_data;
          if (i_col_reg_write) col_data_d = i_col_reg_data;
          if (i_row_reg_write || i_col_reg_write) begin
            state_d = S_SETUP;
            timer_d = SHIFT_LOAD;
          end else begin
            state_d = S_KEY;
            timer_d = KEY_LOAD;
          end
        end
      end
      S_SETUP: begin
        if (timer_q == 8'd0) begin
          state_d = S_HIGH;
          timer_d = SHIFT_LOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (timer_q == 8'd0) begin
          inc_row = req_row_q;
          inc_col = req_col_q;
          if (req_key_q) begin
            state_d = S_KEY;
            timer_d = KEY_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_KEY: begin
        if (timer_q == 8'd0) state_d = S_DONE;
        else                 timer_d = timer_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins are decoded from the next state and then registered. This keeps
    // them aligned with the state register and gives them no combinational
    // path to an output.
    row_clk_d = (state_d == S_HIGH) && req_row_d;
    col_clk_d = (state_d == S_HIGH) && req_col_d;
    key_d     = (state_d == S_KEY);
    ready_d   = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);

    // A clear in the same cycle as an increment takes priority.
    if (i_cnt_clear)  row_cnt_d = '0;
    else if (inc_row) row_cnt_d = row_cnt_q + NB_CNT'(1);
    else              row_cnt_d = row_cnt_q;

    if (i_cnt_clear)  col_cnt_d = '0;
    else if (inc_col) col_cnt_d = col_cnt_q + NB_CNT'(1);
    else              col_cnt_d = col_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      req_row_q  <= 1'b0;
      req_col_q  <= 1'b0;
      req_key_q  <= 1'b0;
      row_data_q <= 1'b0;
      col_data_q <= 1'b0;
      row_clk_q  <= 1'b0;
      col_clk_q  <= 1'b0;
      key_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_row_q  <= req_row_d;
      req_col_q  <= req_col_d;
      req_key_q  <= req_key_d;
      row_data_q <= row_data_d;
      col_data_q <= col_data_d;
      row_clk_q  <= row_clk_d;
      col_clk_q  <= col_clk_d;
      key_q      <= key_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
    end
  end

  assign o_write_ready   = ready_q;
  assign o_busy          = busy_q;
  assign o_chip_row_data = row_data_q;
  assign o_chip_row_clk  = row_clk_q;
  assign o_chip_col_data = col_data_q;
  assign o_chip_col_clk  = col_clk_q;
  assign o_chip_key      = key_q;
  assign o_row_count     = row_cnt_q;
  assign o_col_count     = col_cnt_q;

endmodule

// File: tb/tb_chip_cfg_writer.sv
// Testbench for chip_cfg_writer.
// The driver issues transactions and pushes the expected outcome of each
// one, taken from a reference model, onto exp_q. The monitor gathers pin
// activity for each transaction and compares it against the front of the
// queue whenever o_write_ready is high.
module tb_chip_cfg_writer;
  localparam int CD  = 2;
  localparam int KP  = 4;
  localparam int NB  = 8;
  localparam int MOD = 1 << NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          row_data, row_wr, col_data, col_wr, key_wr, cnt_clr;
  logic          wr_ready, busy, p_row_data, p_row_clk, p_col_data, p_col_clk, p_key;
  logic [NB-1:0] row_count, col_count;

  chip_cfg_writer #(.CLK_DIV(CD), .KEY_PULSE(KP), .NB_CNT(NB)) dut (
    .clk(clk), .rst(rst),
    .i_row_reg_data(row_data), .i_row_reg_write(row_wr),
    .i_col_reg_data(col_data), .i_col_reg_write(col_wr),
    .i_key_wren(key_wr), .i_cnt_clear(cnt_clr),
    .o_write_ready(wr_ready), .o_busy(busy),
    .o_chip_row_data(p_row_data), .o_chip_row_clk(p_row_clk),
    .o_chip_col_data(p_col_data), .o_chip_col_clk(p_col_clk),
    .o_chip_key(p_key), .o_row_count(row_count), .o_col_count(col_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    int lat;     // busy cycles including the done cycle
    int rclk;    // cycles with row_clk high
    int cclk;
    int rfirst;  // busy-cycle index of the first row_clk high (0 = none)
    int cfirst;
    int key;     // cycles with key high
    int rdata;
    int cdata;
    int rcnt;
    int ccnt;
  } exp_t;

  exp_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: pin values and counters as the spec defines them.
  int m_rdata = 0, m_cdata = 0, m_rcnt = 0, m_ccnt = 0;

  function automatic void chk(string nm, int act, int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endfunction

  function automatic void model_push(bit r, bit c, bit k, bit rd, bit cdat, bit clr_at_inc);
    exp_t e;
    if (r) begin m_rdata = rd;   m_rcnt = (m_rcnt + 1) % MOD; end
    if (c) begin m_cdata = cdat; m_ccnt = (m_ccnt + 1) % MOD; end
    if (clr_at_inc) begin m_rcnt = 0; m_ccnt = 0; end
    e.lat    = ((r || c) ? 2 * CD : 0) + (k ? KP : 0) + 1;
    e.rclk   = r ? CD : 0;
    e.cclk   = c ? CD : 0;
    e.rfirst = r ? CD + 1 : 0;
    e.cfirst = c ? CD + 1 : 0;
    e.key    = k ? KP : 0;
    e.rdata  = m_rdata;
    e.cdata  = m_cdata;
    e.rcnt   = m_rcnt;
    e.ccnt   = m_ccnt;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  int a_lat = 0, a_r = 0, a_c = 0, a_rf = 0, a_cf = 0, a_k = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      a_lat = 0; a_r = 0; a_c = 0; a_rf = 0; a_cf = 0; a_k = 0;
    end else begin
      if (busy) a_lat++;
      if (p_row_clk) begin a_r++; if (a_rf == 0) a_rf = a_lat; end
      if (p_col_clk) begin a_c++; if (a_cf == 0) a_cf = a_lat; end
      if (p_key) a_k++;
      if (wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency",   a_lat, e.lat);
          chk("row_clk_w", a_r,   e.rclk);
          chk("col_clk_w", a_c,   e.cclk);
          chk("row_clk_t", a_rf,  e.rfirst);
          chk("col_clk_t", a_cf,  e.cfirst);
          chk("key_w",     a_k,   e.key);
          chk("row_data",  int'(p_row_data), e.rdata);
          chk("col_data",  int'(p_col_data), e.cdata);
          chk("row_count", int'(row_count),  e.rcnt);
          chk("col_count", int'(col_count),  e.ccnt);
        end
        a_lat = 0; a_r = 0; a_c = 0; a_rf = 0; a_cf = 0; a_k = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(bit r, bit c, bit k, bit rd, bit cdat);
    row_wr = r; col_wr = c; key_wr = k; row_data = rd; col_data = cdat;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1'b1; break; end
    end
    chk("done_seen", int'(ok), 1);
  endtask

  // A single transaction: the request is dropped right after the edge that
  // samples the done pulse.
  task automatic run_txn(bit r, bit c, bit k, bit rd, bit cdat);
    @(negedge clk);
    model_push(r, c, k, rd, cdat, 1'b0);
    set_req(r, c, k, rd, cdat);
    wait_done();
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
  endtask

  // The request is held one cycle past the done pulse, so a second
  // transaction must start.
  task automatic run_hold_long(bit r, bit c, bit k, bit rd, bit cdat);
    @(negedge clk);
    model_push(r, c, k, rd, cdat, 1'b0);
    model_push(r, c, k, rd, cdat, 1'b0);
    set_req(r, c, k, rd, cdat);
    wait_done();
    @(posedge clk);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    wait_done();
    @(posedge clk); #1;
  endtask

  task automatic idle_clear();
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    m_rcnt = 0; m_ccnt = 0;
  endtask

  // i_cnt_clear is asserted on the very edge that leaves HIGH, which is the
  // edge that would otherwise increment the counters.
  task automatic run_clear_at_inc(bit r, bit c);
    @(negedge clk);
    model_push(r, c, 1'b0, 1'b1, 1'b1, 1'b1);
    set_req(r, c, 0, 1, 1);
    @(posedge clk);                 // capture edge
    repeat (2 * CD - 1) @(posedge clk);
    @(negedge clk); cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    wait_done();
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_row_data"}, int'(p_row_data), 0);
    chk({tag, "_row_clk"},  int'(p_row_clk),  0);
    chk({tag, "_col_data"}, int'(p_col_data), 0);
    chk({tag, "_col_clk"},  int'(p_col_clk),  0);
    chk({tag, "_key"},      int'(p_key),      0);
    chk({tag, "_ready"},    int'(wr_ready),   0);
    chk({tag, "_busy"},     int'(busy),       0);
    chk({tag, "_row_cnt"},  int'(row_count),  0);
    chk({tag, "_col_cnt"},  int'(col_count),  0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit r, c, k, seen;
    rst = 1'b1; cnt_clr = 1'b0;
    set_req(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed cases
    run_txn(1, 0, 0, 1, 0);        // row only, data 1
    run_txn(1, 1, 0, 0, 1);        // row 0 + col 1 together
    run_txn(0, 0, 1, 0, 0);        // key only
    run_txn(0, 1, 1, 0, 0);        // col + key, col data 0
    run_hold_long(1, 0, 0, 0, 0);  // held one cycle too long -> two txns
    run_txn(0, 1, 0, 0, 1);        // col only; the row pin must hold its value

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      k = 1'($urandom_range(0, 1));
      if (!r && !c && !k) k = 1'b1;
      run_txn(r, c, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) idle_clear();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset while in HIGH aborts the transaction.
    @(negedge clk);
    set_req(1, 1, 1, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p_row_clk) begin seen = 1'b1; break; end
    end
    chk("reach_high", int'(seen), 1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    set_req(0, 0, 0, 0, 0);
    m_rdata = 0; m_cdata = 0; m_rcnt = 0; m_ccnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);   // any done pulse here is unexpected

    // 256 row writes wrap the 8-bit row counter back to 0.
    for (int i = 0; i < MOD; i++) run_txn(1, 0, 0, 1'($urandom_range(0, 1)), 0);
    @(negedge clk);
    chk("row_wrap", int'(row_count), 0);

    // A clear on the same edge as an increment wins.
    run_txn(0, 1, 0, 0, 1);
    run_txn(1, 0, 0, 1, 0);
    run_clear_at_inc(1, 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Overall time limit, so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
